// File: rtl/tl_xbar_pkg.sv
// Shared crossbar definitions: arbiter FSM encoding and a round-robin index helper.
package tl_xbar_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Next index in round-robin order over n ports, wrapping n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tl_skid_buf.sv
// Two-entry skid buffer: registered outputs, full throughput, input ready = not full.
module tl_skid_buf #(
  parameter int W = 67
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_hs;

  assign in_ready = !skid_valid;
  assign in_hs    = in_valid && in_ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      // Output slot frees up: the skid entry is older, so it drains first.
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_hs;
        if (in_hs) out_data <= in_data;
      end
    end else if (in_hs) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/tl_arb_mux.sv
// N-to-1 TileLink round-robin arbiter with per-message lock.
// Define TL_ARB_OUT_REG_EN to register the outputs through a 2-entry skid buffer.
module tl_arb_mux
  import tl_xbar_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 64,
  parameter int SEL_W  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N-1:0]        valid_i,
  output logic [N-1:0]        ready_o,
  input  logic [N*DATA_W-1:0] data_i,
  input  logic [N-1:0]        last_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                last_o,
  output logic [SEL_W-1:0]    sel_o
);

  arb_state_e        state;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  lock_idx;
  logic [SEL_W-1:0]  idle_idx;
  logic [SEL_W-1:0]  scan_idx;
  logic [SEL_W-1:0]  grant;
  logic              idle_found;
  logic              grant_any;
  logic              arb_valid;
  logic              arb_ready;
  logic              arb_hs;
  logic              arb_last;
  logic [DATA_W-1:0] arb_data;

  // Scan starts just after the last winner, so that winner has lowest priority.
  always_comb begin
    idle_found = 1'b0;
    idle_idx   = '0;
    scan_idx   = ptr;
    for (int k = 0; k < N; k++) begin
      scan_idx = SEL_W'(rr_next(int'(scan_idx), N));
      if (!idle_found && valid_i[scan_idx]) begin
        idle_found = 1'b1;
        idle_idx   = scan_idx;
      end
    end
  end

  assign grant     = (state == ARB_LOCKED) ? lock_idx : idle_idx;
  assign grant_any = rst_ni && ((state == ARB_LOCKED) || idle_found);
  assign arb_valid = grant_any && valid_i[grant];
  assign arb_last  = last_i[grant];
  assign arb_data  = data_i[int'(grant)*DATA_W +: DATA_W];
  assign arb_hs    = arb_valid && arb_ready;

  always_comb begin
    ready_o = '0;
    if (grant_any) ready_o[grant] = arb_ready;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ARB_IDLE;
      ptr      <= SEL_W'(N - 1);
      lock_idx <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (idle_found) begin
            // A single-beat message finishing on its grant cycle never locks.
            if (arb_hs && arb_last) begin
              ptr <= idle_idx;
            end else begin
              state    <= ARB_LOCKED;
              lock_idx <= idle_idx;
            end
          end
        end
        ARB_LOCKED: begin
          if (arb_hs && arb_last) begin
            state <= ARB_IDLE;
            ptr   <= lock_idx;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

`ifdef TL_ARB_OUT_REG_EN
  logic [DATA_W+SEL_W:0] buf_out;

  tl_skid_buf #(
    .W(DATA_W + SEL_W + 1)
  ) u_skid (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .in_valid (arb_valid),
    .in_ready (arb_ready),
    .in_data  ({grant, arb_last, arb_data}),
    .out_valid(valid_o),
    .out_ready(ready_i),
    .out_data (buf_out)
  );

  assign sel_o  = buf_out[DATA_W+SEL_W:DATA_W+1];
  assign last_o = buf_out[DATA_W];
  assign data_o = buf_out[DATA_W-1:0];
`else
  assign arb_ready = ready_i;
  assign valid_o   = arb_valid;
  assign data_o    = arb_data;
  assign last_o    = arb_last;
  assign sel_o     = grant;
`endif

endmodule

// File: tb/tb_tl_arb_mux.sv
// Scoreboard bench for tl_arb_mux: stimulus queues expected beats, a monitor checks output handshakes.
module tb_tl_arb_mux;

  localparam int N      = 4;
  localparam int DATA_W = 64;
  localparam int SEL_W  = 2;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        valid_i = '0;
  logic [N-1:0]        ready_o;
  logic [N*DATA_W-1:0] data_i;
  logic [N-1:0]        last_i = '0;
  logic                valid_o;
  logic                ready_i = 1'b0;
  logic [DATA_W-1:0]   data_o;
  logic                last_o;
  logic [SEL_W-1:0]    sel_o;
  logic [DATA_W-1:0]   dat [N];

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    data_i = '0;
    for (int i = 0; i < N; i++) data_i[i*DATA_W +: DATA_W] = dat[i];
  end

  tl_arb_mux #(.N(N), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .last_i (last_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o),
    .last_o (last_o),
    .sel_o  (sel_o)
  );

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_beat(input int sel, input logic last, input logic [DATA_W-1:0] data);
    beat_t b;
    b.sel  = SEL_W'(sel);
    b.last = last;
    b.data = data;
    exp_q.push_back(b);
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic r);
    @(posedge clk);
    #1;
    valid_i = v;
    last_i  = l;
    ready_i = r;
  endtask

  // Monitor: every output handshake must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) begin
      beat_t b;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: unexpected sel=%0d data=%0h last=%0b, expected none", sel_o, data_o, last_o);
      end else begin
        b = exp_q.pop_front();
        if (sel_o !== b.sel || data_o !== b.data || last_o !== b.last) begin
          errors++;
          $display("FAIL beat: got sel=%0d data=%0h last=%0b, expected sel=%0d data=%0h last=%0b",
                   sel_o, data_o, last_o, b.sel, b.data, b.last);
        end else begin
          $display("beat ok: sel=%0d data=%0h last=%0b", sel_o, data_o, last_o);
        end
      end
    end
  end

  initial begin
    int accepted;
    for (int i = 0; i < N; i++) dat[i] = '0;

    // Held in reset with everything asserted: outputs stay quiet.
    valid_i = '1; last_i = '1; ready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_valid_o", DATA_W'(valid_o), '0);
      check("rst_ready_o", DATA_W'(ready_o), '0);
    end
    valid_i = '0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_valid_o", DATA_W'(valid_o), '0);
    check("idle_ready_o", DATA_W'(ready_o), '0);

    // Round-robin over four single-beat streams.
    for (int i = 0; i < N; i++) dat[i] = 64'h1000_0000 + 64'(i);
    for (int c = 0; c < 8; c++) expect_beat(c % 4, 1'b1, 64'h1000_0000 + 64'(c % 4));
    for (int c = 0; c < 8; c++) begin
      drive(4'b1111, 4'b1111, 1'b1);
      if (c == 0) begin
        @(negedge clk);
`ifdef TL_ARB_OUT_REG_EN
        check("first_latency", DATA_W'(valid_o), 64'd0);
`else
        check("first_latency", DATA_W'(valid_o), 64'd1);
`endif
      end
    end
    drive(4'b0000, 4'b0000, 1'b1);
    repeat (2) @(posedge clk);

`ifdef TL_ARB_OUT_REG_EN
    // Downstream stalled: the buffer absorbs exactly two beats.
    for (int i = 0; i < N; i++) dat[i] = 64'h8000 + 64'(i);
    expect_beat(0, 1'b1, 64'h8000);
    expect_beat(1, 1'b1, 64'h8001);
    accepted = 0;
    for (int c = 0; c < 5; c++) begin
      drive(4'b1111, 4'b1111, 1'b0);
      @(negedge clk);
      if (ready_o != '0) accepted++;
    end
    check("stall_accepted", DATA_W'(accepted), 64'd2);
    check("stall_ready_o", DATA_W'(ready_o), '0);
    drive(4'b0000, 4'b0000, 1'b1);
    repeat (3) @(posedge clk);
`else
    // Input 1 sends a 4-beat message while input 2 waits; lock holds input 1.
    dat[2] = 64'h3000;
    for (int b = 0; b < 4; b++) expect_beat(1, b == 3, 64'h2000 + 64'(b));
    expect_beat(2, 1'b1, 64'h3000);
    for (int b = 0; b < 4; b++) begin
      drive(4'b0110, {2'b01, (b == 3), 1'b0}, 1'b1);
      dat[1] = 64'h2000 + 64'(b);
    end
    drive(4'b0100, 4'b0100, 1'b1);
    drive(4'b0000, 4'b0000, 1'b1);

    // Input 3 granted under backpressure; input 0 must wait.
    dat[3] = 64'h4000;
    dat[0] = 64'h5000;
    expect_beat(3, 1'b1, 64'h4000);
    expect_beat(0, 1'b1, 64'h5000);
    for (int c = 0; c < 5; c++) begin
      drive((c == 0) ? 4'b1000 : 4'b1001, 4'b1001, 1'b0);
      @(negedge clk);
      check("stall_sel", DATA_W'(sel_o), 64'd3);
      check("stall_data", data_o, 64'h4000);
      check("stall_ready_o", DATA_W'(ready_o), '0);
    end
    drive(4'b1001, 4'b1001, 1'b1);
    @(negedge clk);
    check("release_ready_o", DATA_W'(ready_o), 64'b1000);
    drive(4'b0001, 4'b0001, 1'b1);
    drive(4'b0000, 4'b0000, 1'b1);

    // Reset in the middle of a message from input 2 abandons it.
    expect_beat(2, 1'b0, 64'h6000);
    expect_beat(2, 1'b0, 64'h6001);
    for (int b = 0; b < 3; b++) begin
      drive(4'b0100, 4'b0000, 1'b1);
      dat[2] = 64'h6000 + 64'(b);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid_o", DATA_W'(valid_o), '0);
    check("midrst_ready_o", DATA_W'(ready_o), '0);
    @(negedge clk);
    valid_i = '0;
    rst_n = 1'b1;
    dat[0] = 64'h7000;
    dat[2] = 64'h7002;
    expect_beat(0, 1'b1, 64'h7000);
    drive(4'b0101, 4'b0101, 1'b1);
    @(negedge clk);
    check("post_rst_sel", DATA_W'(sel_o), 64'd0);
    drive(4'b0000, 4'b0000, 1'b1);
`endif

    // Every expected beat must have appeared within a bounded time.
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    check("queue_drained", DATA_W'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_arb_mux.md
# tl_arb_mux

N-to-1 TileLink channel arbiter with round-robin fairness and message lock. It sits directly downstream of the per-master `tl_demux` instances in the crossbar. For each slave port it merges the N demux outputs targeting that slave into one channel. It holds the grant for the full multi-beat message and reports the winning index for response routing.

## Interface
- `N`, 4: number of input ports.
- `DATA_W`, 64: channel payload width in bits; opaque to this block.
- `SEL_W`, 2: width of the port index; must satisfy 2^SEL_W >= N.
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `valid_i` in N: per-input valid.
- `ready_o` out N: per-input ready.
- `data_i` in N*DATA_W: input payloads; input i occupies `[i*DATA_W +: DATA_W]`.
- `last_i` in N: per-input marker; 1 means the current beat is the final beat of its message.
- `valid_o` out 1: merged valid.
- `ready_i` in 1: downstream ready.
- `data_o` out DATA_W: payload of the granted input.
- `last_o` out 1: `last_i` of the granted input.
- `sel_o` out SEL_W: index of the granted input.

## Operation
- A handshake (hs) occurs when valid and ready are both 1 in the same cycle.
- The FSM has two states, IDLE and LOCKED. Registers: `ptr` (SEL_W bits, last winner) and `lock_idx` (SEL_W bits).
- IDLE grant:
  - The grant goes to the first asserted `valid_i`, scanning from index `ptr+1` with wrap at N (index N-1 wraps to 0).
  - If no input is valid, there is no grant and `valid_o` = 0.
- LOCKED grant:
  - The grant is `lock_idx` unconditionally.
  - `valid_o` = `valid_i[lock_idx]`.
  - Other inputs are ignored.
- Datapath: `data_o`, `last_o` and `sel_o` follow the granted input. `ready_o[g]` = `ready_i` for the granted index g; all other `ready_o` bits are 0.
- Transitions:
  - IDLE, grant present, hs with `last`=1: stay IDLE; `ptr` <= g.
  - IDLE, grant present, no hs (stall) or hs with `last`=0: go to LOCKED; `lock_idx` <= g.
  - LOCKED, hs with `last`=1: go to IDLE; `ptr` <= `lock_idx`.
  - LOCKED, otherwise: stay LOCKED.
- Once presented, a beat's grant never changes until it handshakes. This keeps `valid_o`/`data_o` stable under backpressure, as TileLink requires.
- A single-beat message that completes in the same cycle it is granted never enters LOCKED.
- Indices >= N are never granted. Register values >= N must not occur.

## Timing
- Reset values: state IDLE, `ptr` = N-1 (input 0 wins first), `lock_idx` = 0.
- While in reset, with the output register absent, `ready_o` = 0 and `valid_o` = 0 regardless of inputs.
- The base path is combinational: 0-cycle latency from `valid_i`/`data_i` to the outputs and from `ready_i` to `ready_o`.
- Throughput: one beat per cycle. Back-to-back messages from different inputs incur no bubble.
- Multiple inputs asserting valid in the same cycle resolve purely by the round-robin order.
- A `valid_i` dropped mid-message by a locked input gives `valid_o` = 0. The lock is held; no other input is granted.
- Reset asserted mid-message: the block returns to IDLE immediately (asynchronously). The partial message is abandoned.

## Configuration
- `TL_ARB_OUT_REG_EN` defined:
  - A 2-entry skid buffer is inserted after the arbiter.
  - `valid_o`, `data_o`, `last_o` and `sel_o` are registered; latency is 1 cycle; full throughput is kept.
  - The arbiter-side ready is "buffer not full", so `ready_o` no longer depends combinationally on `ready_i`.
  - Reset values: buffer empty, `valid_o` = 0, `data_o` = 0, `last_o` = 0, `sel_o` = 0.
- `TL_ARB_OUT_REG_EN` undefined: the combinational path exactly as described above.

## Structure
- A shared package `tl_xbar_pkg` holds:
  - the FSM state encoding (`ARB_IDLE`, `ARB_LOCKED`);
  - a round-robin next-index helper function, reusable by other xbar arbiters.
- One sub-module, `tl_skid_buf` (parameter `W` = DATA_W+SEL_W+1). It is instantiated only under `TL_ARB_OUT_REG_EN`.

## Test plan
- Reset release, all `valid_i` = 0 -> `valid_o` = 0, `ready_o` = 0000.
- `valid_i` = 1111, all `last_i` = 1, `ready_i` = 1, for 8 cycles -> `sel_o` sequence 0,1,2,3,0,1,2,3.
- Input 1 sends a 4-beat message (`last_i` on the 4th beat) while input 2 is constantly valid -> `sel_o` = 1 for all 4 beats, then `sel_o` = 2 on the next cycle.
- Grant to input 3 with `ready_i` = 0 for 5 cycles while input 0 raises valid -> `sel_o` stays 3 and `data_o` stays stable. When `ready_i` = 1: one hs on input 3, then input 0 is granted.
- Reset asserted during beat 2 of a 4-beat message from input 2 -> state returns to IDLE and `ptr` to N-1. After release, with input 0 and input 2 both valid, input 0 wins.
- With `TL_ARB_OUT_REG_EN` defined: the single-beat round-robin stream from the round-robin scenario appears at the output 1 cycle later, with no bubbles. With `ready_i` held 0, at most 2 beats are accepted before `ready_o` = 0000.
